// File: rtl/ip4_rtl_pkg.sv
// Shared ip4 AXI widths, response/state enums and the INCR address step.
// Pure declarations; no logic or timing of its own.
package ip4_rtl_pkg;

    localparam int WID_AXI_ID     = 4;
    localparam int WID_AXI_DATA   = 32;
    localparam int WID_AXI_ADDR   = 32;
    localparam int BYTES_AXI_DATA = WID_AXI_DATA / 8;
    localparam int SIZE_MAX       = $clog2(BYTES_AXI_DATA);

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_slv_st_e;

    // INCR step; wraps silently at 2^WID_AXI_ADDR, no 4KB boundary handling.
    function automatic logic [WID_AXI_ADDR-1:0] axi_next_addr(
        input logic [WID_AXI_ADDR-1:0] addr,
        input logic [2:0]              size
    );
        return addr + (WID_AXI_ADDR'(1) << size);
    endfunction

endpackage

// File: rtl/ip4_axi_wr_slv_if.sv
// AXI3 write address/data/response channels between an ip4 master and slave.
interface ip4_axi_wr_slv_if;
    import ip4_rtl_pkg::*;

    logic [WID_AXI_ID-1:0]     awid;
    logic [WID_AXI_ADDR-1:0]   awaddr;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic                      awvalid;
    logic                      awready;

    logic [WID_AXI_ID-1:0]     wid;
    logic [WID_AXI_DATA-1:0]   wdata;
    logic [BYTES_AXI_DATA-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [WID_AXI_ID-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/ip4_axi_wr_slv.sv
// AXI3 write slave: one INCR burst at a time, each beat becomes a wr_en one cycle after its w handshake.
// wready = ~wr_en | wr_ready (1-deep output reg); optional IP4_AXI_WID_CHECK_EN flags wid != awid as SLVERR.
module ip4_axi_wr_slv
    import ip4_rtl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    ip4_axi_wr_slv_if.slave           axi,
    output logic                      wr_en,
    output logic [WID_AXI_ADDR-1:0]   wr_addr,
    output logic [WID_AXI_DATA-1:0]   wr_data,
    output logic [BYTES_AXI_DATA-1:0] wr_be,
    input  logic                      wr_ready
);

    wr_slv_st_e              state_q, state_d;
    logic [WID_AXI_ID-1:0]   id_q;
    logic [WID_AXI_ADDR-1:0] addr_q;
    logic [3:0]              len_q;
    logic [2:0]              size_q;
    logic [3:0]              cnt_q;
    logic                    err_q;
    logic                    sup_q;
    logic                    last_q;

    logic aw_hs, w_hs, retire, beat_last, size_bad, wid_bad;

    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid & axi.wready;
    assign retire    = ~wr_en | wr_ready;
    assign beat_last = (cnt_q == len_q);
    assign size_bad  = (axi.awsize > 3'(SIZE_MAX));

`ifdef IP4_AXI_WID_CHECK_EN
    assign wid_bad = (axi.wid != id_q);
`else
    logic unused_wid;
    assign unused_wid = ^axi.wid;
    assign wid_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_hs) state_d = DATA;
            // Leave only once the final beat's write has drained from the output register.
            DATA:    if (last_q && retire) state_d = RESP;
            RESP:    if (axi.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi.awready = (state_q == IDLE) && !rst;
        axi.wready  = (state_q == DATA) && !last_q && retire;
        axi.bvalid  = (state_q == RESP);
        axi.bid     = id_q;
        axi.bresp   = err_q ? SLVERR : OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            sup_q   <= 1'b0;
            last_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
        end else begin
            if (aw_hs) begin
                id_q   <= axi.awid;
                addr_q <= axi.awaddr;
                len_q  <= axi.awlen;
                size_q <= axi.awsize;
                cnt_q  <= '0;
                err_q  <= size_bad;
                sup_q  <= size_bad;
                last_q <= 1'b0;
            end
            if (w_hs) begin
                wr_addr <= addr_q;
                wr_data <= axi.wdata;
                wr_be   <= axi.wstrb;
                wr_en   <= ~(sup_q | wid_bad);
                addr_q  <= axi_next_addr(addr_q, size_q);
                cnt_q   <= cnt_q + 4'd1;
                last_q  <= beat_last;
                if (wid_bad)
                    sup_q <= 1'b1;
                // A misplaced wlast is only reported; the beat is still written.
                if (wid_bad || (axi.wlast != beat_last))
                    err_q <= 1'b1;
            end else if (wr_ready) begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ip4_axi_wr_slv.sv
// Directed bench for ip4_axi_wr_slv: bursts, backpressure, protocol errors, reset mid-burst.
module tb_ip4_axi_wr_slv;
    import ip4_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ip4_axi_wr_slv_if axi();

    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [3:0]  cap_be[$];

    ip4_axi_wr_slv dut (
        .clk      (clk),
        .rst      (rst),
        .axi      (axi.slave),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .wr_ready (wr_ready)
    );

    // A write retires on the posedge following a negedge where wr_en & wr_ready.
    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            cap_be.push_back(wr_be);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_be.delete();
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size);
        bit done = 1'b0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (axi.awready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        axi.awvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL aw_handshake: got no awready, required awready within 50 cycles");
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic [3:0] id);
        bit done = 1'b0;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wid = id;
        axi.wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (axi.wready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        axi.wvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL w_handshake: got no wready for data %h, required wready within 50 cycles", data);
        end
    endtask

    // Waits for bvalid, checks id/resp and write count at that point, holds bready low, then accepts.
    task automatic wait_b(input string name, input logic [3:0] exp_id, input logic [1:0] exp_resp,
                          input int hold, input int exp_writes);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (axi.bvalid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_bvalid: got no bvalid, required bvalid within 100 cycles", name);
            @(posedge clk); #1;
            return;
        end
        checks++;
        if (cap_addr.size() !== exp_writes) begin
            errors++;
            $display("FAIL %s_writes_at_b: got %0d writes, required %0d", name, cap_addr.size(), exp_writes);
        end
        checks++;
        if (axi.bid !== exp_id || axi.bresp !== exp_resp) begin
            errors++;
            $display("FAIL %s_bresp: got bid %0d bresp %0d, required bid %0d bresp %0d",
                     name, axi.bid, axi.bresp, exp_id, exp_resp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (axi.bvalid !== 1'b1 || axi.bid !== exp_id || axi.bresp !== exp_resp) begin
                errors++;
                $display("FAIL %s_b_hold%0d: got bvalid %b bid %0d bresp %0d, required 1 %0d %0d",
                         name, i, axi.bvalid, axi.bid, axi.bresp, exp_id, exp_resp);
            end
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.bvalid !== 1'b0 || axi.awready !== 1'b1) begin
            errors++;
            $display("FAIL %s_b_done: got bvalid %b awready %b, required 0 1", name, axi.bvalid, axi.awready);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_writes(input string name, input logic [31:0] base, input logic [31:0] d0,
                                input logic [3:0] be, input int n);
        checks++;
        if (cap_addr.size() !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, cap_addr.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            if (cap_addr.size() > i) begin
                checks++;
                if (cap_addr[i] !== base + 32'(4 * i) || cap_data[i] !== d0 + 32'(i) || cap_be[i] !== be) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got addr %h data %h be %h, required %h %h %h", name, i,
                             cap_addr[i], cap_data[i], cap_be[i], base + 32'(4 * i), d0 + 32'(i), be);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_ready = 1'b1;
        axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
        axi.wvalid = 1'b0; axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (axi.awready !== 1'b0 || axi.wready !== 1'b0 || axi.bvalid !== 1'b0 ||
            axi.bid !== 4'd0 || axi.bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_axi: got awready %b wready %b bvalid %b bid %0d bresp %0d, required all 0",
                     axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0 || wr_be !== 4'd0) begin
            errors++;
            $display("FAIL reset_wr: got wr_en %b addr %h data %h be %h, required all 0",
                     wr_en, wr_addr, wr_data, wr_be);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.awready !== 1'b1 || axi.wready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got awready %b wready %b, required 1 0", axi.awready, axi.wready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        clear_cap();
        send_aw(4'd3, 32'h100, 4'd0, 3'd2);
        send_w(32'hDEADBEEF, 4'hF, 1'b1, 4'd3);
        wait_b("single", 4'd3, 2'b00, 0, 1);
        check_writes("single", 32'h100, 32'hDEADBEEF, 4'hF, 1);
    endtask

    task automatic test_burst4();
        clear_cap();
        send_aw(4'd7, 32'h200, 4'd3, 3'd2);
        for (int i = 0; i < 4; i++)
            send_w(32'hA000_0000 + 32'(i), 4'h5, (i == 3), 4'd7);
        wait_b("burst4", 4'd7, 2'b00, 0, 4);
        check_writes("burst4", 32'h200, 32'hA000_0000, 4'h5, 4);
    endtask

    task automatic test_backpressure();
        clear_cap();
        send_aw(4'd9, 32'h300, 4'd3, 3'd2);
        send_w(32'h1111_0000, 4'hF, 1'b0, 4'd9);
        send_w(32'h1111_0001, 4'hF, 1'b0, 4'd9);
        wr_ready = 1'b0;
        axi.wdata = 32'h1111_0002; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wid = 4'd9;
        axi.wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (axi.wready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 32'h304 || wr_data !== 32'h1111_0001) begin
                errors++;
                $display("FAIL stall%0d: got wready %b wr_en %b addr %h data %h, required 0 1 00000304 11110001",
                         i, axi.wready, wr_en, wr_addr, wr_data);
            end
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        send_w(32'h1111_0002, 4'hF, 1'b0, 4'd9);
        send_w(32'h1111_0003, 4'hF, 1'b1, 4'd9);
        wait_b("bp", 4'd9, 2'b00, 5, 4);
        check_writes("bp", 32'h300, 32'h1111_0000, 4'hF, 4);
    endtask

    task automatic test_wlast_err();
        clear_cap();
        send_aw(4'd1, 32'h400, 4'd3, 3'd2);
        for (int i = 0; i < 4; i++)
            send_w(32'hB000_0000 + 32'(i), 4'h3, (i == 1), 4'd1);
        wait_b("wlast", 4'd1, 2'b10, 0, 4);
        check_writes("wlast", 32'h400, 32'hB000_0000, 4'h3, 4);
    endtask

    task automatic test_size_err();
        clear_cap();
        send_aw(4'd2, 32'h800, 4'd3, 3'd3);
        for (int i = 0; i < 4; i++)
            send_w(32'hC000_0000 + 32'(i), 4'hF, (i == 3), 4'd2);
        wait_b("size", 4'd2, 2'b10, 0, 0);
    endtask

    task automatic test_reset_mid();
        clear_cap();
        send_aw(4'd4, 32'h600, 4'd3, 3'd2);
        send_w(32'hD000_0000, 4'hF, 1'b0, 4'd4);
        send_w(32'hD000_0001, 4'hF, 1'b0, 4'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0 || wr_be !== 4'd0 ||
            axi.awready !== 1'b0 || axi.wready !== 1'b0 || axi.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got wr_en %b addr %h awready %b wready %b bvalid %b, required all 0",
                     wr_en, wr_addr, axi.awready, axi.wready, axi.bvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (axi.bvalid !== 1'b0 || axi.awready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_idle%0d: got bvalid %b awready %b, required 0 1", i, axi.bvalid, axi.awready);
            end
        end
        @(posedge clk); #1;
        clear_cap();
        send_aw(4'd6, 32'h700, 4'd1, 3'd2);
        send_w(32'hE000_0000, 4'hF, 1'b0, 4'd6);
        send_w(32'hE000_0001, 4'hF, 1'b1, 4'd6);
        wait_b("after_rst", 4'd6, 2'b00, 0, 2);
        check_writes("after_rst", 32'h700, 32'hE000_0000, 4'hF, 2);
    endtask

    task automatic test_wid();
        clear_cap();
        send_aw(4'd5, 32'h500, 4'd1, 3'd2);
        send_w(32'hF000_0000, 4'hF, 1'b0, 4'd6);
        send_w(32'hF000_0001, 4'hF, 1'b1, 4'd5);
`ifdef IP4_AXI_WID_CHECK_EN
        wait_b("wid", 4'd5, 2'b10, 0, 0);
`else
        wait_b("wid", 4'd5, 2'b00, 0, 2);
        check_writes("wid", 32'h500, 32'hF000_0000, 4'hF, 2);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_backpressure();
        test_wlast_err();
        test_size_err();
        test_wid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
